// File: rtl/iomem_pkg.sv
// iomem_pkg -- shared constants for the iomem_intr memory / interrupt timer.
//   Register offsets are relative to DEPTH. The top four words of the array
//   are replaced by the timer register window.
//   Also holds the address decode helper used by the top level.
package iomem_pkg;

   // Register word offsets relative to DEPTH
   localparam int REG_CTRL   = -4;
   localparam int REG_PERIOD = -3;
   localparam int REG_COUNT  = -2;
   localparam int REG_STATUS = -1;

   // CTRL bit indices
   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;

   // STATUS field positions
   localparam int STATUS_INT       = 0;
   localparam int STATUS_MISSED_LO = 8;
   localparam int STATUS_MISSED_HI = 15;
   localparam int MISSED_W         = STATUS_MISSED_HI - STATUS_MISSED_LO + 1;

   typedef enum logic [2:0] {
      SEL_MEM,
      SEL_CTRL,
      SEL_PERIOD,
      SEL_COUNT,
      SEL_STATUS
   } sel_e;

   // Map a word address onto either the array or one of the registers.
   function automatic sel_e decode(input int depth, input int addr);
      if (addr == depth + REG_CTRL)   return SEL_CTRL;
      if (addr == depth + REG_PERIOD) return SEL_PERIOD;
      if (addr == depth + REG_COUNT)  return SEL_COUNT;
      if (addr == depth + REG_STATUS) return SEL_STATUS;
      return SEL_MEM;
   endfunction

endpackage

// File: rtl/iomem_intr_if.sv
// iomem_intr_if -- bus control and interrupt handshake of iomem_intr.
//   CS_, RD_, WR_ : active-low chip select / read / write strobes
//   Addr          : word address
//   Int_ack       : interrupt acknowledge (level, sampled on the clock)
//   Int_req       : latched interrupt request
// The data bus itself is a direct inout port of iomem_intr so the
// tri-state resolves at a module boundary.
interface iomem_intr_if #(
   parameter int ADDR_W = 10
);
   logic              CS_;
   logic              RD_;
   logic              WR_;
   logic [ADDR_W-1:0] Addr;
   logic              Int_ack;
   logic              Int_req;

   modport master (output CS_, RD_, WR_, Addr, Int_ack, input Int_req);
   modport slave  (input CS_, RD_, WR_, Addr, Int_ack, output Int_req);
endinterface

// File: rtl/iomem_intr_timer.sv
// iomem_intr_timer -- programmable interrupt timer with latched request.
//   clk, srst        : clock, synchronous active-high reset
//   wr_ctrl/period/status : one-cycle register write strobes (already decoded)
//   wdata            : write data
//   int_ack          : interrupt acknowledge
//   ctrl_rd, period_rd, count_rd, status_rd : register read values
//   int_req          : latched interrupt request
// Optional: IOMEM_MISSED_CNT_EN adds an 8-bit saturating MISSED counter
// reported in STATUS[15:8]; without it those bits read 0.
module iomem_intr_timer
   import iomem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int PERIOD_RST = 300,
   parameter int EN_RST     = 1
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              wr_ctrl,
   input  logic              wr_period,
   input  logic              wr_status,
   input  logic [DATA_W-1:0] wdata,
   input  logic              int_ack,
   output logic [DATA_W-1:0] ctrl_rd,
   output logic [DATA_W-1:0] period_rd,
   output logic [DATA_W-1:0] count_rd,
   output logic [DATA_W-1:0] status_rd,
   output logic              int_req
);

   logic             en_reg;
   logic             periodic_reg;
   logic             int_req_reg;
   logic [CNT_W-1:0] period_reg;
   logic [CNT_W-1:0] count_reg;
   logic [MISSED_W-1:0] missed;

   logic cfg_wr;
   logic run;
   logic tick;
   logic clr;
   logic unused_wdata;

   // A configuration write restarts the count and suppresses any tick.
   assign cfg_wr = wr_ctrl | wr_period;
   assign run    = en_reg && (period_reg != '0);
   assign tick   = run && !cfg_wr && (count_reg == period_reg);
   assign clr    = int_ack | (wr_status & wdata[STATUS_INT]);
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk) begin
      if (srst) begin
         en_reg       <= 1'(EN_RST);
         periodic_reg <= 1'b0;
         period_reg   <= CNT_W'(PERIOD_RST);
         count_reg    <= '0;
         int_req_reg  <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en_reg       <= wdata[CTRL_EN];
            periodic_reg <= wdata[CTRL_PERIODIC];
         end
         if (wr_period)
            period_reg <= wdata[CNT_W-1:0];

         if (cfg_wr)
            count_reg <= '0;
         else if (tick) begin
            // periodic: restart; one-shot: hold count and disarm
            if (periodic_reg)
               count_reg <= '0;
            else
               en_reg <= 1'b0;
         end else if (run)
            count_reg <= count_reg + CNT_W'(1);

         // a tick on the same edge as a clear keeps the request set
         if (tick)
            int_req_reg <= 1'b1;
         else if (clr)
            int_req_reg <= 1'b0;
      end
   end

`ifdef IOMEM_MISSED_CNT_EN
   logic [MISSED_W-1:0] missed_reg;

   always_ff @(posedge clk) begin
      if (srst)
         missed_reg <= '0;
      else if (wr_status)
         missed_reg <= '0;
      else if (tick && int_req_reg && (missed_reg != '1))
         missed_reg <= missed_reg + MISSED_W'(1);
   end

   assign missed = missed_reg;
`else
   assign missed = '0;
`endif

   always_comb begin
      ctrl_rd                = '0;
      ctrl_rd[CTRL_EN]       = en_reg;
      ctrl_rd[CTRL_PERIODIC] = periodic_reg;
      period_rd              = DATA_W'(period_reg);
      count_rd               = DATA_W'(count_reg);
      status_rd              = '0;
      status_rd[STATUS_INT]  = int_req_reg;
      status_rd[STATUS_MISSED_HI:STATUS_MISSED_LO] = missed;
   end

   assign int_req = int_req_reg;

endmodule

// File: rtl/iomem_intr.sv
// iomem_intr -- DEPTH x DATA_W memory-mapped I/O memory with an interrupt
// timer occupying the top four words (CTRL, PERIOD, COUNT, STATUS).
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset (array contents are kept)
//   bus   : CS_/RD_/WR_/Addr/Int_ack/Int_req (iomem_intr_if.slave)
//   Data  : tri-state data bus, driven only while CS_=0, RD_=0, WR_=1
// Reads are combinational; writes land on the rising edge.
// Optional: IOMEM_MISSED_CNT_EN enables the MISSED counter in STATUS[15:8].
module iomem_intr
   import iomem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 16,
   parameter int PERIOD_RST = 300,
   parameter int EN_RST     = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   iomem_intr_if.slave      bus,
   inout  wire [DATA_W-1:0] Data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   sel_e              sel;
   logic              wr_en;
   logic              rd_en;
   logic              int_req;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] ctrl_rd;
   logic [DATA_W-1:0] period_rd;
   logic [DATA_W-1:0] count_rd;
   logic [DATA_W-1:0] status_rd;

   assign sel   = decode(DEPTH, int'(bus.Addr));
   assign wr_en = !bus.CS_ && !bus.WR_ && !Reset;
   // RD_ and WR_ low together is treated as a write: never drive then.
   assign rd_en = !bus.CS_ && !bus.RD_ && bus.WR_;

   always_ff @(posedge Clk) begin
      if (wr_en && (sel == SEL_MEM))
         mem[bus.Addr] <= Data;
   end

   iomem_intr_timer #(
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W),
      .PERIOD_RST (PERIOD_RST),
      .EN_RST     (EN_RST)
   ) u_timer (
      .clk       (Clk),
      .srst      (Reset),
      .wr_ctrl   (wr_en && (sel == SEL_CTRL)),
      .wr_period (wr_en && (sel == SEL_PERIOD)),
      .wr_status (wr_en && (sel == SEL_STATUS)),
      .wdata     (Data),
      .int_ack   (bus.Int_ack),
      .ctrl_rd   (ctrl_rd),
      .period_rd (period_rd),
      .count_rd  (count_rd),
      .status_rd (status_rd),
      .int_req   (int_req)
   );

   always_comb begin
      rdata = mem[bus.Addr];
      case (sel)
         SEL_CTRL:   rdata = ctrl_rd;
         SEL_PERIOD: rdata = period_rd;
         SEL_COUNT:  rdata = count_rd;
         SEL_STATUS: rdata = status_rd;
         default:    ;
      endcase
   end

   assign Data        = rd_en ? rdata : {DATA_W{1'bz}};
   assign bus.Int_req = int_req;

endmodule

// File: tb/tb_iomem_intr.sv
// tb_iomem_intr -- self-checking bench for iomem_intr.
//   Directed scenarios (reset defaults, first-interrupt latency, memory and
//   tri-state behaviour, periodic mode, set-wins, W1C, MISSED counter when
//   IOMEM_MISSED_CNT_EN is defined, reset mid-run) followed by randomized
//   bus traffic, all compared with a behavioural model of the register
//   rules kept in this file.
`timescale 1ns/1ps
module tb_iomem_intr;
   import iomem_pkg::*;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 10;
   localparam int CNT_W      = 16;
   localparam int PERIOD_RST = 300;
   localparam int EN_RST     = 1;
   localparam int DEPTH      = 2 ** ADDR_W;
   localparam int A_CTRL     = DEPTH + REG_CTRL;
   localparam int A_PERIOD   = DEPTH + REG_PERIOD;
   localparam int A_COUNT    = DEPTH + REG_COUNT;
   localparam int A_STATUS   = DEPTH + REG_STATUS;

   logic clk = 1'b0;
   logic rst;
   logic tb_drv;
   logic [DATA_W-1:0] tb_wdata;
   wire  [DATA_W-1:0] data;

   assign data = tb_drv ? tb_wdata : {DATA_W{1'bz}};

   iomem_intr_if #(.ADDR_W(ADDR_W)) bus ();

   iomem_intr #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .PERIOD_RST (PERIOD_RST),
      .EN_RST     (EN_RST)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus.slave),
      .Data  (data)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_en, m_periodic, m_int;
   int m_per, m_count, m_missed;
   logic [DATA_W-1:0] m_mem [int];

   // Apply the register rules for one rising edge given the inputs now on the bus.
   task automatic model_edge();
      bit wr, tk, clr;
      int a;
      if (rst) begin
         m_int = 0; m_count = 0; m_en = (EN_RST != 0); m_periodic = 0;
         m_per = PERIOD_RST; m_missed = 0;
         return;
      end
      a  = int'(bus.Addr);
      wr = !bus.CS_ && !bus.WR_;
      tk = 0;
      if (wr && (a == A_CTRL || a == A_PERIOD)) begin
         if (a == A_CTRL) begin
            m_en = tb_wdata[0];
            m_periodic = tb_wdata[1];
         end else
            m_per = int'(tb_wdata[CNT_W-1:0]);
         m_count = 0;
      end else if (m_en && m_per != 0) begin
         if (m_count == m_per) begin
            tk = 1;
            if (m_periodic) m_count = 0;
            else m_en = 0;
         end else
            m_count++;
      end
      clr = bus.Int_ack || (wr && a == A_STATUS && tb_wdata[0]);
`ifdef IOMEM_MISSED_CNT_EN
      if (wr && a == A_STATUS) m_missed = 0;
      else if (tk && m_int && m_missed < 255) m_missed++;
`endif
      if (tk) m_int = 1;
      else if (clr) m_int = 0;
      if (wr && a < A_CTRL) m_mem[a] = tb_wdata;
   endtask

   function automatic logic [DATA_W-1:0] model_read(input int a);
      logic [DATA_W-1:0] v;
      v = '0;
      case (a)
         A_CTRL:   begin v[0] = m_en; v[1] = m_periodic; end
         A_PERIOD: v = DATA_W'(m_per);
         A_COUNT:  v = DATA_W'(m_count);
         A_STATUS: begin v[0] = m_int; v[15:8] = 8'(m_missed); end
         default:  v = m_mem.exists(a) ? m_mem[a] : {DATA_W{1'bx}};
      endcase
      return v;
   endfunction

   // ---------------- bus helpers ----------------
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("int_req", bus.Int_req, m_int);
   endtask

   task automatic idle_cycle(input bit ack);
      bus.Int_ack = ack;
      cycle();
      bus.Int_ack = 1'b0;
   endtask

   task automatic bus_write(input int a, input logic [DATA_W-1:0] d);
      bus.CS_ = 1'b0; bus.WR_ = 1'b0; bus.RD_ = 1'b1;
      bus.Addr = ADDR_W'(a); tb_drv = 1'b1; tb_wdata = d;
      $display("WR addr=0x%03h data=0x%08h ack=%0b", a, d, bus.Int_ack);
      cycle();
      bus.CS_ = 1'b1; bus.WR_ = 1'b1; tb_drv = 1'b0;
   endtask

   task automatic bus_read(input int a, input string tag, output logic [DATA_W-1:0] v);
      bus.CS_ = 1'b0; bus.RD_ = 1'b0; bus.WR_ = 1'b1; bus.Addr = ADDR_W'(a);
      #1;
      v = data;
      $display("RD addr=0x%03h data=0x%08h", a, v);
      check(tag, v, model_read(a));
      bus.CS_ = 1'b1; bus.RD_ = 1'b1;
   endtask

   // True when any data bit is actively driven high (z reads as non-1).
   function automatic bit bus_has_one();
      for (int i = 0; i < DATA_W; i++)
         if (data[i] === 1'b1) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rise;
      bit prev;
      int rises[$];
      logic [DATA_W-1:0] rv;
      logic [DATA_W-1:0] r;
      int a, op;

      bus.CS_ = 1'b1; bus.RD_ = 1'b1; bus.WR_ = 1'b1; bus.Addr = '0;
      bus.Int_ack = 1'b0; tb_drv = 1'b0; tb_wdata = '0; rst = 1'b1;

      // ---- reset and defaults ----
      cycle();
      cycle();
      rst = 1'b0;
      bus_read(A_CTRL, "rst_ctrl", rv);
      check("rst_ctrl_val", rv, 1);
      bus_read(A_PERIOD, "rst_period", rv);
      check("rst_period_val", rv, 300);
      bus_read(A_COUNT, "rst_count", rv);
      bus_read(A_STATUS, "rst_status", rv);

      // ---- first interrupt latency with defaults ----
      rise = 0;
      for (int i = 1; i <= 400 && rise == 0; i++) begin
         cycle();
         if (bus.Int_req === 1'b1) rise = i;
      end
      check("first_rise_edge", rise, 301);
      idle_cycle(1'b1);
      check("ack_clears", bus.Int_req, 0);
      for (int i = 0; i < 3; i++) idle_cycle(1'b0);
      bus_read(A_CTRL, "oneshot_ctrl", rv);
      check("oneshot_en_off", rv, 0);

      // ---- memory and tri-state ----
      bus_write(5, 32'hA5A5_0001);
      bus_read(5, "mem_rd5", rv);
      check("mem_rd5_val", rv, 32'hA5A5_0001);
      bus.CS_ = 1'b1; bus.RD_ = 1'b0; bus.Addr = ADDR_W'(5);
      #1;
      check("hiz_cs_high", bus_has_one(), 0);
      bus.RD_ = 1'b1;
      bus_write(6, 32'hFFFF_0000);
      bus.CS_ = 1'b0; bus.RD_ = 1'b0; bus.WR_ = 1'b0; bus.Addr = ADDR_W'(6);
      #1;
      check("hiz_rd_wr_low", bus_has_one(), 0);
      tb_drv = 1'b1; tb_wdata = 32'h1234_5678;
      cycle();
      bus.CS_ = 1'b1; bus.RD_ = 1'b1; bus.WR_ = 1'b1; tb_drv = 1'b0;
      bus_read(6, "rdwr_lands", rv);
      check("rdwr_lands_val", rv, 32'h1234_5678);

      // ---- periodic mode, PERIOD=4, ack each request ----
      bus_write(A_PERIOD, 4);
      bus_write(A_CTRL, 3);
      prev = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         bus_read(A_COUNT, "per_count", rv);
         idle_cycle(bus.Int_req);
         if (bus.Int_req === 1'b1 && !prev) rises.push_back(i);
         prev = (bus.Int_req === 1'b1);
      end
      check("per_rise_cnt", rises.size(), 4);
      check("per_first_rise", (rises.size() > 0) ? rises[0] : -1, 5);
      for (int k = 1; k < rises.size(); k++)
         check("per_interval", rises[k] - rises[k-1], 5);

      // ---- set wins over ack, then W1C ----
      idle_cycle(1'b1);
      for (int i = 0; i < 10 && m_count != m_per; i++) idle_cycle(1'b0);
      idle_cycle(1'b1);
      check("set_wins", bus.Int_req, 1);
      bus_write(A_STATUS, 1);
      check("w1c_clear", bus.Int_req, 0);

`ifdef IOMEM_MISSED_CNT_EN
      // ---- MISSED counter ----
      bus_write(A_PERIOD, 2);
      bus_write(A_CTRL, 3);
      bus_write(A_STATUS, 1);
      for (int i = 0; i < 11; i++) cycle();
      bus_read(A_STATUS, "missed_status", rv);
      check("missed_status_val", rv, 32'h0301);
      bus_write(A_STATUS, 0);
      bus_read(A_STATUS, "missed_clr", rv);
      check("missed_clr_val", rv[15:8], 0);
`endif

      // ---- randomized traffic ----
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 9);
         bus.Int_ack = ($urandom_range(0, 3) == 0);
         r = $urandom;
         case (op)
            0, 1: bus_write($urandom_range(16, 31), r);
            2: begin r[15:0] = 16'($urandom_range(0, 6)); bus_write(A_PERIOD, r); end
            3: bus_write(A_CTRL, r);
            4: bus_write(A_COUNT, r);
            5: bus_write(A_STATUS, r);
            6, 7: begin
               a = $urandom_range(16, 31);
               if (!m_mem.exists(a)) a = A_CTRL + $urandom_range(0, 3);
               bus_read(a, "rand_read", rv);
               cycle();
            end
            default: cycle();
         endcase
         bus.Int_ack = 1'b0;
      end

      // ---- reset during a periodic run ----
      bus_write(A_PERIOD, 3);
      bus_write(A_CTRL, 3);
      for (int i = 0; i < 20 && bus.Int_req !== 1'b1; i++) cycle();
      check("pre_reset_int", bus.Int_req, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_reset_int", bus.Int_req, 0);
      bus_read(A_COUNT, "mid_reset_count", rv);
      check("mid_reset_count_val", rv, 0);
      bus_read(A_PERIOD, "mid_reset_period", rv);
      check("mid_reset_period_val", rv, 300);
      bus_read(A_CTRL, "mid_reset_ctrl", rv);
      check("mid_reset_ctrl_val", rv, 1);
      cycle();
      bus_read(5, "retain_mem5", rv);
      check("retain_mem5_val", rv, 32'hA5A5_0001);
      bus_read(6, "retain_mem6", rv);
      check("retain_mem6_val", rv, 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/iomem_intr.md
Name: iomem_intr

Overview:
Parametrised memory-mapped I/O memory for the testbench and SoC bus. It is a DEPTH x DATA_W array on a tri-state data bus with active-low CS_/RD_/WR_. It also carries a software-programmable interrupt timer that replaces the fixed free-running interrupt generator. The timer supports one-shot and periodic modes, and Int_req stays latched until acknowledged.

Parameters:
- DATA_W, 32, data bus and word width (>=16).
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- CNT_W, 16, timer counter and PERIOD register width (<= DATA_W).
- PERIOD_RST, 300, PERIOD value after reset.
- EN_RST, 1, timer-enable value after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- CS_  in  1  chip select, active-low.
- RD_  in  1  read strobe, active-low.
- WR_  in  1  write strobe, active-low.
- Addr  in  ADDR_W  word address.
- Data  inout  DATA_W  bidirectional data bus.
- Int_ack  in  1  interrupt acknowledge, level, sampled on Clk.
- Int_req  out  1  latched interrupt request.

Behaviour:
- Reset: Int_req=0, counter=0, CTRL.EN=EN_RST, CTRL.PERIODIC=0, PERIOD=PERIOD_RST, MISSED=0. Memory array contents are not reset.
- Register window: the top 4 words replace array words.
  - DEPTH-4 CTRL: bit0 EN, bit1 PERIODIC.
  - DEPTH-3 PERIOD: R/W, low CNT_W bits.
  - DEPTH-2 COUNT: read-only; writes are ignored.
  - DEPTH-1 STATUS: bit0 Int_req, W1C. Bits[15:8] MISSED when the optional feature is compiled in, else 0.
  - Unused register bits read 0.
- Read: asynchronous and combinational. Data is driven iff !CS_ & !RD_ & WR_; otherwise Data is hi-Z. RD_ and WR_ low together: no drive; the write proceeds.
- Write: on posedge Clk when !CS_ & !WR_ & !Reset. Array or register updated at that edge.
- Timer counter:
  - Each edge with EN=1 and PERIOD!=0: if counter==PERIOD, tick. Else counter+1.
  - On tick in periodic mode: counter<=0.
  - On tick in one-shot mode: counter holds and EN<=0.
  - EN=0 or PERIOD=0: counter holds and no tick.
- Writing PERIOD or CTRL clears counter to 0 at the same edge, and no tick occurs on that edge.
- Latency: with PERIOD=P after reset release, Int_req rises on the (P+1)th rising edge.
- Int_req set/clear:
  - Tick sets Int_req.
  - Int_ack=1 at an edge clears Int_req.
  - STATUS write with bit0=1 clears Int_req.
  - Tick and clear on the same edge: Int_req stays 1 (set wins).
  - Ack while Int_req=0: no effect.
- Reset mid-operation: reset dominates all writes, ticks and acks on that edge.

Optional Feature:
- Macro IOMEM_MISSED_CNT_EN.
- With it: an 8-bit MISSED counter in STATUS[15:8] increments on each tick that occurs while Int_req is already 1. It saturates at 255 and is cleared by any STATUS write.
- Without it: STATUS[15:8] reads 0, no counter logic.

Decomposition:
- Package iomem_pkg:
  - register offsets: REG_CTRL=-4, REG_PERIOD=-3, REG_COUNT=-2, REG_STATUS=-1, relative to DEPTH;
  - CTRL bit indices: CTRL_EN=0, CTRL_PERIODIC=1;
  - STATUS field positions: bit 0 and MISSED 15:8.
- Sub-module iomem_intr_timer: counter, EN/PERIODIC/PERIOD registers, Int_req latch, MISSED counter. Top level holds the array, address decode and tri-state.

Test Plan:
- Reset, then idle with defaults -> Int_req=0 through edge 300, Int_req=1 at edge 301. Int_ack pulse for one edge -> Int_req=0 next cycle and stays 0 (one-shot, EN reads 0).
- Write 0xA5A5_0001 to Addr 5, read Addr 5 -> Data=0xA5A5_0001. With CS_=1 -> Data=Z. RD_=0 and WR_=0 together -> Data=Z and the write lands.
- CTRL=3 (periodic), PERIOD=4 -> Int_req set at edge 5 after the write. Ack every request -> a rise every 5 edges; COUNT reads cycle 0..4.
- Int_ack held high on the tick edge -> Int_req=1 after that edge (set wins). Clear via STATUS write of 0x1 -> Int_req=0.
- With IOMEM_MISSED_CNT_EN, periodic PERIOD=2, no ack for 4 ticks -> STATUS=0x0301. Write STATUS -> MISSED=0.
- Assert Reset during a periodic run with Int_req=1 -> next edge Int_req=0, COUNT=0, PERIOD=300, CTRL=0x1. Previously written array words are retained.
